// File: rtl/dcf77_encoder_if.sv
// Frame hand-off channel into the DCF77 encoder: a 59-bit minute frame
// in receiver data_hold layout with a valid/ready handshake.
interface dcf77_encoder_if;
    logic [58:0] frame;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        output frame,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/dcf77_encoder.sv
// DCF77 transmit-side encoder: turns a double-buffered 59-bit frame into a
// demodulated pulse train, one bit per second, bit 0 first, second 59 blank.
module dcf77_encoder #(
    parameter int CLK_HZ    = 24_000_000,
    parameter int T_ZERO_MS = 100,
    parameter int T_ONE_MS  = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    dcf77_encoder_if.slave        s_frame,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic [5:0]            o_sec,
    output logic                  o_sec_tick,
    output logic                  o_min_start,
    output logic                  o_underrun
);

    localparam int               DIV      = CLK_HZ / 1000;
    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [9:0]       MS_LAST  = 10'd999;
    localparam logic [5:0]       SEC_LAST = 6'd59;
    localparam logic [9:0]       W_ZERO   = 10'(T_ZERO_MS);
    localparam logic [9:0]       W_ONE    = 10'(T_ONE_MS);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start;

    logic [DIV_W-1:0]   r_div;
    logic [9:0]         r_ms;
    logic [5:0]         r_sec;
    logic [58:0]        r_act;
    logic [58:0]        r_hold;
    logic               r_hold_full;
    logic               r_sec_tick;
    logic               r_min_start;
    logic               r_underrun;

    logic               w_run;
    logic               w_accept;
    logic               w_ms_strobe;
    logic               w_sec_wrap;
    logic               w_boundary;
    logic               w_bit;
    logic [9:0]         w_width;
    logic               w_tx;

    assign w_run       = (r_state == ST_RUN);
    assign w_accept    = s_frame.frame_valid && !r_hold_full;
    assign w_ms_strobe = w_run && (r_div == DIV_LAST);
    assign w_sec_wrap  = w_ms_strobe && (r_ms == MS_LAST);
    assign w_boundary  = w_sec_wrap && (r_sec == SEC_LAST);

    // Second 59 carries no bit, so the act index is only consulted below it.
    assign w_bit   = (r_sec != SEC_LAST) ? r_act[r_sec] : 1'b0;
    assign w_width = w_bit ? W_ONE : W_ZERO;
    assign w_tx    = w_run && (r_sec != SEC_LAST) && (r_ms < w_width);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                    w_start      = 1'b1;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_ms        <= '0;
            r_sec       <= '0;
            r_sec_tick  <= 1'b0;
            r_min_start <= 1'b0;
        end else begin
            r_sec_tick  <= 1'b0;
            r_min_start <= 1'b0;
            if (w_start) begin
                r_div       <= '0;
                r_ms        <= '0;
                r_sec       <= '0;
                r_sec_tick  <= 1'b1;
                r_min_start <= 1'b1;
            end else if (w_run) begin
                r_div <= w_ms_strobe ? '0 : r_div + 1'b1;
                if (w_ms_strobe) begin
                    r_ms <= (r_ms == MS_LAST) ? 10'd0 : r_ms + 10'd1;
                end
                if (w_sec_wrap) begin
                    r_sec      <= (r_sec == SEC_LAST) ? 6'd0 : r_sec + 6'd1;
                    r_sec_tick <= 1'b1;
                end
                if (w_boundary) begin
                    r_min_start <= 1'b1;
                end
            end
        end
    end

    // A frame offered on the minute edge with hold empty bypasses hold entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_start) begin
                r_act <= s_frame.frame;
            end else if (w_run) begin
                if (w_boundary) begin
                    if (r_hold_full) begin
                        r_act       <= r_hold;
                        r_hold_full <= 1'b0;
                    end else if (w_accept) begin
                        r_act <= s_frame.frame;
                    end else begin
                        r_underrun <= 1'b1;
                    end
                end else if (w_accept) begin
                    r_hold      <= s_frame.frame;
                    r_hold_full <= 1'b1;
                end
            end
        end
    end

    assign s_frame.frame_ready = !r_hold_full;
    assign o_tx                = w_tx;
    assign o_busy              = w_run;
    assign o_sec               = r_sec;
    assign o_sec_tick          = r_sec_tick;
    assign o_min_start         = r_min_start;
    assign o_underrun          = r_underrun;

endmodule
